// File: rtl/register_hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks EX/MEM/WB destinations,
// stalls on load-use, and drives EX forwarding and WB bypass selects.
module register_hazard_scoreboard #(
  parameter int REG_INDEX_WIDTH     = 5,
  parameter int STALL_COUNTER_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           decodeValid,
  input  logic [REG_INDEX_WIDTH-1:0]     decodeRs1,
  input  logic [REG_INDEX_WIDTH-1:0]     decodeRs2,
  input  logic [REG_INDEX_WIDTH-1:0]     decodeRd,
  input  logic                           decodeUsesRs1,
  input  logic                           decodeUsesRs2,
  input  logic                           decodeWritesRd,
  input  logic                           decodeIsLoad,
  input  logic                           memStall,
  input  logic                           flush,
  output logic                           decodeStall,
  output logic [1:0]                     forwardSelLHS,
  output logic [1:0]                     forwardSelRHS,
  output logic                           decodeBypassLHS,
  output logic                           decodeBypassRHS,
  output logic [STALL_COUNTER_WIDTH-1:0] stallCount
);

  typedef logic [REG_INDEX_WIDTH-1:0] regIdx_t;

  logic    exValid, exWritesRd, exIsLoad;
  logic    exUsesRs1, exUsesRs2;
  regIdx_t exRd, exRs1, exRs2;
  logic    memValid, memWritesRd, memIsLoad;
  regIdx_t memRd;
  logic    wbValid, wbWritesRd, wbIsLoad;
  regIdx_t wbRd;

  logic exQual, memQual, wbQual;
  logic loadUse, issueValid;
  logic unusedLoadFlags;

  // Load flags past EX are kept for visibility only.
  assign unusedLoadFlags = memIsLoad ^ wbIsLoad;

  // x0 writers never participate in hazards.
  assign exQual  = exValid & exWritesRd & (exRd != '0);
  assign memQual = memValid & memWritesRd & (memRd != '0);
  assign wbQual  = wbValid & wbWritesRd & (wbRd != '0);

  assign loadUse = decodeValid & exQual & exIsLoad &
                   ((decodeUsesRs1 & (decodeRs1 == exRd)) |
                    (decodeUsesRs2 & (decodeRs2 == exRd)));

  // Gated by reset so every output reads 0 while held in reset.
  assign decodeStall = resetN & (memStall | loadUse);
  assign issueValid  = decodeValid & ~loadUse & ~flush;

  assign decodeBypassLHS = decodeValid & decodeUsesRs1 &
                           wbQual & (wbRd == decodeRs1);
  assign decodeBypassRHS = decodeValid & decodeUsesRs2 &
                           wbQual & (wbRd == decodeRs2);

  function automatic logic [1:0] fwdSel(
    input logic    uses,
    input regIdx_t rs
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (exValid && uses && memQual && memRd == rs)
      sel = 2'b01;
    else if (wbQual && wbRd == rs)
      sel = 2'b10;
    return sel;
  endfunction

  // EX operand sources, youngest producer first.
  always_comb begin
    forwardSelLHS = fwdSel(exUsesRs1, exRs1);
    forwardSelRHS = fwdSel(exUsesRs2, exRs2);
  end

  // Slot pipeline: freeze on memStall, else shift and issue.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      exValid     <= 1'b0;
      exWritesRd  <= 1'b0;
      exIsLoad    <= 1'b0;
      exUsesRs1   <= 1'b0;
      exUsesRs2   <= 1'b0;
      exRd        <= '0;
      exRs1       <= '0;
      exRs2       <= '0;
      memValid    <= 1'b0;
      memWritesRd <= 1'b0;
      memIsLoad   <= 1'b0;
      memRd       <= '0;
      wbValid     <= 1'b0;
      wbWritesRd  <= 1'b0;
      wbIsLoad    <= 1'b0;
      wbRd        <= '0;
    end else if (!memStall) begin
      wbValid     <= memValid;
      wbWritesRd  <= memWritesRd;
      wbIsLoad    <= memIsLoad;
      wbRd        <= memRd;
      memValid    <= exValid;
      memWritesRd <= exWritesRd;
      memIsLoad   <= exIsLoad;
      memRd       <= exRd;
      exValid     <= issueValid;
      exWritesRd  <= decodeWritesRd;
      exIsLoad    <= decodeIsLoad;
      exUsesRs1   <= decodeUsesRs1;
      exUsesRs2   <= decodeUsesRs2;
      exRd        <= decodeRd;
      exRs1       <= decodeRs1;
      exRs2       <= decodeRs2;
    end
  end

  // Saturating count of stalled decode cycles.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      stallCount <= '0;
    else if (decodeStall && stallCount != '1)
      stallCount <= stallCount + STALL_COUNTER_WIDTH'(1);
  end

endmodule

// File: tb/tb_register_hazard_scoreboard.sv
// Randomized scoreboard bench for register_hazard_scoreboard
// against a slot-array reference model.
module tb_register_hazard_scoreboard;

  localparam int RW = 5;
  localparam int CW = 32;
  localparam int SW = 3;
  localparam longint MAX_BIG = 64'hFFFF_FFFF;
  localparam longint MAX_SMALL = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetN = 1'b0;
  logic          decodeValid = 1'b0;
  logic [RW-1:0] decodeRs1 = '0;
  logic [RW-1:0] decodeRs2 = '0;
  logic [RW-1:0] decodeRd = '0;
  logic          decodeUsesRs1 = 1'b0;
  logic          decodeUsesRs2 = 1'b0;
  logic          decodeWritesRd = 1'b0;
  logic          decodeIsLoad = 1'b0;
  logic          memStall = 1'b0;
  logic          flush = 1'b0;

  logic          decodeStall;
  logic [1:0]    forwardSelLHS, forwardSelRHS;
  logic          decodeBypassLHS, decodeBypassRHS;
  logic [CW-1:0] stallCount;

  logic          smallStall;
  logic [1:0]    smallFwdL, smallFwdR;
  logic          smallBypL, smallBypR;
  logic [SW-1:0] smallCount;

  register_hazard_scoreboard #(
    .REG_INDEX_WIDTH(RW), .STALL_COUNTER_WIDTH(CW)
  ) dut (
    .clk(clk), .resetN(resetN),
    .decodeValid(decodeValid),
    .decodeRs1(decodeRs1), .decodeRs2(decodeRs2),
    .decodeRd(decodeRd),
    .decodeUsesRs1(decodeUsesRs1),
    .decodeUsesRs2(decodeUsesRs2),
    .decodeWritesRd(decodeWritesRd),
    .decodeIsLoad(decodeIsLoad),
    .memStall(memStall), .flush(flush),
    .decodeStall(decodeStall),
    .forwardSelLHS(forwardSelLHS),
    .forwardSelRHS(forwardSelRHS),
    .decodeBypassLHS(decodeBypassLHS),
    .decodeBypassRHS(decodeBypassRHS),
    .stallCount(stallCount)
  );

  register_hazard_scoreboard #(
    .REG_INDEX_WIDTH(RW), .STALL_COUNTER_WIDTH(SW)
  ) dutSmall (
    .clk(clk), .resetN(resetN),
    .decodeValid(decodeValid),
    .decodeRs1(decodeRs1), .decodeRs2(decodeRs2),
    .decodeRd(decodeRd),
    .decodeUsesRs1(decodeUsesRs1),
    .decodeUsesRs2(decodeUsesRs2),
    .decodeWritesRd(decodeWritesRd),
    .decodeIsLoad(decodeIsLoad),
    .memStall(memStall), .flush(flush),
    .decodeStall(smallStall),
    .forwardSelLHS(smallFwdL),
    .forwardSelRHS(smallFwdR),
    .decodeBypassLHS(smallBypL),
    .decodeBypassRHS(smallBypR),
    .stallCount(smallCount)
  );

  typedef struct {
    bit v, wr, ld, u1, u2;
    int rd, rs1, rs2;
  } slot_t;

  typedef struct {
    bit stall, bl, br;
    bit [1:0] fl, fr;
    longint cnt, cntS;
  } exp_t;

  exp_t   q[$];
  slot_t  pipe[3];
  slot_t  lastDec;
  bit     lastRn, lastDv, lastLu, lastMs, lastFl, lastStall;
  longint cnt, cntS;
  int     checks = 0;
  int     errors = 0;

  function automatic bit qual(slot_t s);
    return s.v && s.wr && s.rd != 0;
  endfunction

  function automatic bit [1:0] fwd(bit uses, int rs);
    if (pipe[0].v && uses && qual(pipe[1]) && pipe[1].rd == rs)
      return 2'b01;
    if (qual(pipe[2]) && pipe[2].rd == rs)
      return 2'b10;
    return 2'b00;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    cnt = 0;
    cntS = 0;
  endtask

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic drive(bit rn, bit dv, int r1, int r2, int rd,
                       bit u1, bit u2, bit wr, bit ld,
                       bit ms, bit fl);
    slot_t d;
    exp_t  e;
    bit    lu;
    @(posedge clk);
    #1;
    if (!lastRn) clearModel();
    else begin
      if (lastStall) begin
        if (cnt < MAX_BIG) cnt++;
        if (cntS < MAX_SMALL) cntS++;
      end
      if (!lastMs) begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = lastDec;
        pipe[0].v = lastDv && !lastLu && !lastFl;
      end
    end
    resetN = rn;
    decodeValid = dv;
    decodeRs1 = RW'(r1);
    decodeRs2 = RW'(r2);
    decodeRd = RW'(rd);
    decodeUsesRs1 = u1;
    decodeUsesRs2 = u2;
    decodeWritesRd = wr;
    decodeIsLoad = ld;
    memStall = ms;
    flush = fl;
    if (!rn) clearModel();
    d = '{v: dv, wr: wr, ld: ld, u1: u1, u2: u2,
          rd: rd, rs1: r1, rs2: r2};
    lu = dv && qual(pipe[0]) && pipe[0].ld &&
         ((u1 && r1 == pipe[0].rd) || (u2 && r2 == pipe[0].rd));
    e.stall = rn && (ms || lu);
    e.fl = fwd(pipe[0].u1, pipe[0].rs1);
    e.fr = fwd(pipe[0].u2, pipe[0].rs2);
    e.bl = dv && u1 && qual(pipe[2]) && pipe[2].rd == r1;
    e.br = dv && u2 && qual(pipe[2]) && pipe[2].rd == r2;
    e.cnt = cnt;
    e.cntS = cntS;
    q.push_back(e);
    lastDec = d;
    lastRn = rn;
    lastDv = dv;
    lastLu = lu;
    lastMs = ms;
    lastFl = fl;
    lastStall = e.stall;
  endtask

  task automatic idle(bit rn);
    drive(rn, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pop the expected response for each sampled cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("decodeStall", decodeStall, e.stall);
        chk("forwardSelLHS", forwardSelLHS, e.fl);
        chk("forwardSelRHS", forwardSelRHS, e.fr);
        chk("decodeBypassLHS", decodeBypassLHS, e.bl);
        chk("decodeBypassRHS", decodeBypassRHS, e.br);
        chk("stallCount", stallCount, e.cnt);
        chk("smallStall", smallStall, e.stall);
        chk("smallCount", smallCount, e.cntS);
        if (forwardSelLHS == 2'b01)
          chk("memFwdNotLoadL", dut.memIsLoad, 0);
        if (forwardSelRHS == 2'b01)
          chk("memFwdNotLoadR", dut.memIsLoad, 0);
      end
    end
  end

  initial begin
    int rstHold;
    clearModel();
    lastRn = 0;
    lastStall = 0;
    lastDec = '{default: 0};
    idle(0);
    idle(0);
    repeat (3) idle(1);
    // lw x5 ; add x6,x5,x7 held through its stall
    drive(1, 1, 1, 0, 5, 1, 0, 1, 1, 0, 0);
    drive(1, 1, 5, 7, 6, 1, 1, 1, 0, 0, 0);
    drive(1, 1, 5, 7, 6, 1, 1, 1, 0, 0, 0);
    repeat (3) idle(1);
    // add x5 ; sub x8,x5,x5
    drive(1, 1, 1, 2, 5, 1, 1, 1, 0, 0, 0);
    drive(1, 1, 5, 5, 8, 1, 1, 1, 0, 0, 0);
    repeat (3) idle(1);
    // x3 producers in MEM and WB, consumer behind them
    drive(1, 1, 1, 2, 3, 1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 2, 3, 1, 1, 1, 0, 0, 0);
    drive(1, 1, 3, 3, 4, 1, 1, 1, 0, 0, 0);
    idle(1);
    // x9 producer reaching WB, decode reads rs2=x9
    drive(1, 1, 1, 2, 9, 1, 1, 1, 0, 0, 0);
    idle(1);
    drive(1, 1, 4, 9, 10, 1, 1, 1, 0, 0, 0);
    // memStall held 3 cycles with a flush inside it
    drive(1, 1, 4, 9, 10, 1, 1, 1, 0, 1, 0);
    drive(1, 1, 4, 9, 10, 1, 1, 1, 0, 1, 1);
    drive(1, 1, 4, 9, 10, 1, 1, 1, 0, 1, 0);
    drive(1, 1, 4, 9, 10, 1, 1, 1, 0, 0, 0);
    // long stall saturates the narrow counter, then reset mid-stall
    repeat (10) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    rstHold = 0;
    for (int i = 0; i < 4000; i++) begin
      bit rn;
      if (rstHold == 0 && $urandom_range(0, 199) == 0)
        rstHold = $urandom_range(1, 2);
      rn = (rstHold == 0);
      if (rstHold > 0) rstHold--;
      drive(rn,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 6) == 0,
            $urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < 5 && q.size() > 0; i++)
      @(negedge clk);
    #1;
    chk("queueDrained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
